// File: rtl/sum_sched_pkg.sv
// Shared types and width helpers for the shared serial-sum scheduler.
// Both the top level and the accumulator unit import this package.
package sum_sched_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, RESP} state_t;

  function automatic int sumWidth(input int opw, input int nops);
    return opw + $clog2(nops + 1);
  endfunction

  function automatic int idWidth(input int nreq);
    return (nreq > 2) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/sum_acc_unit.sv
// Captures one operand vector and sums it one operand per cycle through a single adder.
// After NOPS additions it idles and holds the sum until the next load.
module sum_acc_unit
  import sum_sched_pkg::*;
#(
  parameter int NOPS = 9,
  parameter int OPW  = 1,
  parameter int SUMW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [NOPS*OPW-1:0]  ops,
  output logic [SUMW-1:0]      acc,
  output logic                 last
);

  localparam int IDXW = $clog2(NOPS + 1);

  logic [OPW-1:0]  r_ops [NOPS];
  logic [IDXW-1:0] r_idx;
  logic [SUMW-1:0] r_acc;

  // The index parks at NOPS once every operand is summed, which freezes r_acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      r_acc <= '0;
      for (int k = 0; k < NOPS; k++) r_ops[k] <= '0;
    end else if (load) begin
      r_idx <= '0;
      r_acc <= '0;
      for (int k = 0; k < NOPS; k++) r_ops[k] <= ops[k*OPW +: OPW];
    end else if (r_idx < IDXW'(NOPS)) begin
      r_acc <= r_acc + SUMW'(r_ops[r_idx]);
      r_idx <= r_idx + IDXW'(1);
    end
  end

  assign acc  = r_acc;
  assign last = (r_idx == IDXW'(NOPS - 1));

endmodule

// File: rtl/sum_share_sched.sv
// Round-robin arbiter and control FSM that share one serial accumulator among NREQ requesters.
// The accumulator register drives rsp_sum directly; it stays frozen while a response is pending.
module sum_share_sched
  import sum_sched_pkg::*;
#(
  parameter  int NREQ = 2,
  parameter  int NOPS = 9,
  parameter  int OPW  = 1,
  localparam int SUMW = sumWidth(OPW, NOPS),
  localparam int IDW  = idWidth(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*NOPS*OPW-1:0] req_ops,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [SUMW-1:0]          rsp_sum
);

  localparam int VECW = NOPS * OPW;

  state_t          r_state;
  logic [IDW-1:0]  r_rrPtr;
  logic [IDW-1:0]  r_rspId;
  logic            r_rspValid;

  logic            w_found;
  logic [IDW-1:0]  w_winner;
  logic [VECW-1:0] w_winOps;
  logic [NREQ-1:0] w_reqReady;
  logic            w_load;
  logic [SUMW-1:0] w_acc;
  logic            w_last;

  // Two passes give wrap-around priority: requesters at or above rr_ptr first, then the rest.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_winOps = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req_valid[i] && (IDW'(i) >= r_rrPtr)) begin
        w_found  = 1'b1;
        w_winner = IDW'(i);
        w_winOps = req_ops[i*VECW +: VECW];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req_valid[i]) begin
        w_found  = 1'b1;
        w_winner = IDW'(i);
        w_winOps = req_ops[i*VECW +: VECW];
      end
    end
  end

  assign w_load = (r_state == IDLE) && w_found && !rst;

  always_comb begin
    w_reqReady = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_reqReady[i] = w_load && (w_winner == IDW'(i));
    end
  end

  sum_acc_unit #(
    .NOPS (NOPS),
    .OPW  (OPW),
    .SUMW (SUMW)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .ops  (w_winOps),
    .acc  (w_acc),
    .last (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rrPtr    <= '0;
      r_rspId    <= '0;
      r_rspValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_rspId <= w_winner;
            r_rrPtr <= (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + IDW'(1);
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_last) begin
            r_rspValid <= 1'b1;
            r_state    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rspValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = w_reqReady;
  assign rsp_valid = r_rspValid;
  assign rsp_id    = r_rspId;
  assign rsp_sum   = w_acc;

endmodule

// File: doc/sum_share_sched.md
Name: sum_share_sched

Overview:
Round-robin scheduler that shares one serial accumulator among NREQ requesters, each presenting a vector of NOPS operands to be summed. The block grants one requester at a time and captures its operand vector. It sums the operands one per cycle through a single adder, then returns the result with the requester ID over a valid/ready response port. It sits in front of the summation datapath and replaces per-requester multi-operand adder trees.

Parameters:
NREQ, 2, number of requesters (2..8)
NOPS, 9, operands per request (>=2)
OPW, 1, operand width in bits
SUMW, OPW+$clog2(NOPS+1), derived localparam, not overridable; result width (default 5)
IDW, max(1,$clog2(NREQ)), derived localparam; requester ID width

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_ops  in  NREQ*NOPS*OPW  operand vectors; requester r at slice r, operand k at bits [k*OPW +: OPW] within it
rsp_valid  out  1  result valid
rsp_ready  in  1  downstream accepts result
rsp_id  out  IDW  ID of requester whose sum is presented
rsp_sum  out  SUMW  unsigned sum of the NOPS operands

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, acc=0, idx=0, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_sum=0, req_ready=0.
- FSM states: IDLE, ACCUM, RESP.
- IDLE:
  - req_ready is combinational. It is one-hot for the winning requester when any req_valid is high; otherwise it is 0.
  - Winner = first requester with req_valid set, searching from rr_ptr upward with wrap-around.
  - On handshake (req_valid & req_ready): capture the winner's operand vector into an internal register; latch its ID; acc<=0; idx<=0; rr_ptr<=winner+1 mod NREQ; go to ACCUM.
- ACCUM:
  - Each cycle: acc <= acc + zero-extended op[idx]; idx++.
  - After the cycle that adds op[NOPS-1], go to RESP. ACCUM lasts exactly NOPS cycles.
  - req_ready=0 throughout.
- RESP:
  - rsp_valid=1; rsp_sum and rsp_id are registered and held stable until the handshake.
  - On rsp_ready=1: rsp_valid<=0 next cycle and go to IDLE. A new grant is not possible in the same cycle.
- Latency: accept at cycle T gives rsp_valid at T+NOPS+1. Minimum spacing between back-to-back accepts is NOPS+2 cycles.
- Width: SUMW holds NOPS*(2^OPW-1) without overflow. No saturation and no wrap are required.
- Operand changes after the handshake are ignored because the vector is captured at accept.
- A requester that drops req_valid before it is granted simply loses the arbitration. This is not an error.
- rsp_ready high outside RESP has no effect.
- Reset mid-operation (ACCUM or RESP): the in-flight request is discarded with no response. All state returns to reset values, so requester 0 has priority on the next arbitration.
- rsp_valid rising in the same cycle as rst is impossible, because rst dominates all transitions.

Decomposition:
- Package sum_sched_pkg: state enum (IDLE, ACCUM, RESP) and a clog2-based width helper function for SUMW and IDW.
- Sub-module sum_acc_unit holds the operand capture register, idx counter, accumulator and last-operand flag.
  - Inputs: clk, rst, load, ops.
  - Outputs: acc, last.
- The top level holds the round-robin arbiter, the FSM and the response registers.

Test Plan:
- Reset, then req_valid=01, req0 ops all 1 (NOPS=9, OPW=1) -> req_ready=01 at T; rsp_valid at T+10; rsp_sum=9, rsp_id=0.
- req_valid=11 held continuously, rsp_ready=1, after reset -> grants in order 0,1,0,1; rsp_id follows that order; accepts are 11 cycles apart.
- Single request with ops=9'b101010101, rsp_ready held low 6 cycles in RESP -> rsp_sum=5 stable; rsp_valid held high; req_ready=0 on all requesters; IDLE entered the cycle after rsp_ready rises.
- Change req_ops of the granted requester one cycle after accept (all ones to all zeros) -> rsp_sum=9, so the captured value is used.
- Assert rst on the 4th ACCUM cycle -> rsp_valid never rises; next grant with req_valid=11 goes to requester 0.
- Set OPW=4, NOPS=9, all operands 15 -> rsp_sum=135, and SUMW=8 holds it without overflow.
